// File: rtl/ann_weight_loader_if.sv
// ann_weight_loader_if
//   SRAM read bus between the row loader and the external SRAM.
//   One read is outstanding at a time: sram_read_en is a single-cycle
//   strobe and sram_rvalid returns the word an arbitrary number of cycles
//   (>= 1) later.
//   Signals:
//     sram_addr     word address, driven by the loader
//     sram_read_en  one-cycle read strobe, driven by the loader
//     sram_rdata    read data, driven by the SRAM
//     sram_rvalid   read data valid, driven by the SRAM
//   Modports: master = loader side, slave = SRAM side.
interface ann_weight_loader_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16
);
    logic [ADDR_W-1:0] sram_addr;
    logic              sram_read_en;
    logic [DATA_W-1:0] sram_rdata;
    logic              sram_rvalid;

    modport master (
        output sram_addr,
        output sram_read_en,
        input  sram_rdata,
        input  sram_rvalid
    );

    modport slave (
        input  sram_addr,
        input  sram_read_en,
        output sram_rdata,
        output sram_rvalid
    );
endinterface

// File: rtl/ann_weight_loader.sv
// ann_weight_loader
//   Fetches one row (image pixels or one neuron's coefficients) from
//   external SRAM into a local row buffer and pulses image_weights_loaded
//   when the whole row is held. A rising edge on request_coef in IDLE
//   starts a load; load_next/coef_select are latched at that moment.
//   Ports:
//     clk, n_rst            clock (rising edge), async active-low reset
//     request_coef          load request level; 0->1 edge starts a load
//     load_next[1:0]        00 image, 01 layer-1 row, 10 layer-2 row, 11 ignored
//     coef_select[6:0]      neuron row index for coefficient loads
//     sram                  SRAM read bus (master side)
//     image_weights_loaded  one-cycle pulse when the row is complete
//     busy                  a load is in progress
//     buf_valid             buffer holds a complete row
//     buf_addr / buf_data   combinational buffer read port
module ann_weight_loader #(
    parameter int unsigned        DATA_W    = 16,
    parameter int unsigned        ADDR_W    = 16,
    parameter int unsigned        ROW_WORDS = 64,
    parameter logic [ADDR_W-1:0]  IMG_BASE  = 16'h0000,
    parameter logic [ADDR_W-1:0]  L1_BASE   = 16'h0100,
    parameter logic [ADDR_W-1:0]  L2_BASE   = 16'h2100
) (
    input  logic                         clk,
    input  logic                         n_rst,
    input  logic                         request_coef,
    input  logic [1:0]                   load_next,
    input  logic [6:0]                   coef_select,
    ann_weight_loader_if.master          sram,
    output logic                         image_weights_loaded,
    output logic                         busy,
    output logic                         buf_valid,
    input  logic [$clog2(ROW_WORDS)-1:0] buf_addr,
    output logic [DATA_W-1:0]            buf_data
);
    localparam int unsigned CW = $clog2(ROW_WORDS);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        state;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_next;
    logic              req_q;
    logic [1:0]        src_q;
    logic [6:0]        sel_q;
    logic [ADDR_W-1:0] addr_q;
    logic              start;
    logic [DATA_W-1:0] row_buf [ROW_WORDS];

    // Row base address; all arithmetic wraps at ADDR_W bits.
    function automatic logic [ADDR_W-1:0] row_base(input logic [1:0] src,
                                                   input logic [6:0] sel);
        logic [ADDR_W-1:0] off;
        off = ADDR_W'(sel) * ADDR_W'(ROW_WORDS);
        case (src)
            2'b01:   return L1_BASE + off;
            2'b10:   return L2_BASE + off;
            default: return IMG_BASE;
        endcase
    endfunction

    assign start    = (state == S_IDLE) && request_coef && !req_q
                      && (load_next != 2'b11);
    assign cnt_next = cnt + CW'(1);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            req_q     <= 1'b0;
            src_q     <= '0;
            sel_q     <= '0;
            addr_q    <= '0;
            buf_valid <= 1'b0;
        end else begin
            req_q <= request_coef;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        src_q     <= load_next;
                        sel_q     <= coef_select;
                        cnt       <= '0;
                        buf_valid <= 1'b0;
                        addr_q    <= row_base(load_next, coef_select);
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: state <= S_WAIT;
                S_WAIT: begin
                    if (sram.sram_rvalid) begin
                        if (cnt == CW'(ROW_WORDS - 1)) begin
                            // Row complete: valid flag rises with the pulse.
                            buf_valid <= 1'b1;
                            state     <= S_DONE;
                        end else begin
                            cnt    <= cnt_next;
                            addr_q <= row_base(src_q, sel_q) + ADDR_W'(cnt_next);
                            state  <= S_ISSUE;
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Buffer storage is not reset; buf_valid qualifies its contents.
    always_ff @(posedge clk) begin
        if (state == S_WAIT && sram.sram_rvalid)
            row_buf[cnt] <= sram.sram_rdata;
    end

    // sram_addr is a register, so it holds its last value outside ISSUE.
    assign sram.sram_addr        = addr_q;
    assign sram.sram_read_en     = (state == S_ISSUE);
    assign busy                  = (state != S_IDLE);
    assign image_weights_loaded  = (state == S_DONE);
    assign buf_data              = row_buf[buf_addr];
endmodule
